// File: rtl/pif_i2c_front_pkg.sv
// pif_i2c_front_pkg: shared widths, byte-type codes and FSM encoding for the PIF I2C front-end
package pif_i2c_front_pkg;
  localparam int XA_BITS   = 3;
  localparam int TYPE_BITS = 2;
  localparam int XSUBA_MAX = 7;
  localparam int TYPE_ADDR = 0;
  localparam int TYPE_DATA = 1;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } i2c_state_t;
endpackage

// File: rtl/pif_i2c_front_line_sync.sv
// i2c_line_sync: brings SCL/SDA into xclk and flags SCL edges plus START/STOP conditions
module i2c_line_sync (
  input  logic xclk,
  input  logic sys_rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [1:0] scl_s, sda_s;
  logic scl_h, sda_h, scl;
  // Reset to the idle-high bus level so leaving reset never looks like an edge
  always_ff @(posedge xclk or negedge sys_rst)
    if (!sys_rst) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_h <= 1'b1;
      sda_h <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
      scl_h <= scl_s[1];
      sda_h <= sda_s[1];
    end
  assign scl       = scl_s[1];
  assign sda       = sda_s[1];
  assign scl_rise  = scl & ~scl_h;
  assign scl_fall  = ~scl & scl_h;
  assign start_det = scl & scl_h & ~sda & sda_h;
  assign stop_det  = scl & scl_h & sda & ~sda_h;
endmodule

// File: rtl/pif_i2c_front.sv
// pif_i2c_front: I2C slave turning SCL/SDA into XI register strobes and serialising XO read-back
module pif_i2c_front #(
  parameter logic [6:0] I2C_ADDR  = 7'h41,
  parameter int         XA_BITS   = pif_i2c_front_pkg::XA_BITS,
  parameter int         TYPE_BITS = pif_i2c_front_pkg::TYPE_BITS,
  parameter int         XSUBA_MAX = pif_i2c_front_pkg::XSUBA_MAX
) (
  input  logic                   xclk,
  input  logic                   sys_rst,
  input  logic                   scl_i,
  input  logic                   sda_i,
  output logic                   sda_oe,
  output logic                   XI_PWr,
  output logic [2**XA_BITS-1:0]  XI_PRWA,
  output logic                   XI_PRdFinished,
  output logic [XSUBA_MAX:0]     XI_PRdSubA,
  output logic [7-TYPE_BITS:0]   XI_PD,
  input  logic [7:0]             XO,
  output logic                   busy
);
  import pif_i2c_front_pkg::*;
  localparam int PW = 2**XA_BITS;
  i2c_state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, nb;
  logic sda, scl_rise, scl_fall, start_det, stop_det;
  logic sda_oe_n, pwr_n, fin_n, is_addr, is_data, addr_hit;
  logic [PW-1:0] prwa_n;
  logic [XSUBA_MAX:0] sub_n;
  logic [7-TYPE_BITS:0] pd_n;

  i2c_line_sync u_sync (
    .xclk      (xclk),
    .sys_rst   (sys_rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign nb       = {shreg[6:0], sda};
  assign is_addr  = nb[TYPE_BITS-1:0] == TYPE_BITS'(TYPE_ADDR);
  assign is_data  = nb[TYPE_BITS-1:0] == TYPE_BITS'(TYPE_DATA);
  assign addr_hit = shreg[7:1] == I2C_ADDR;
  assign busy     = state != IDLE && state != IGNORE;

  always_ff @(posedge xclk or negedge sys_rst)
    if (!sys_rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      sda_oe         <= 1'b0;
      XI_PWr         <= 1'b0;
      XI_PRWA        <= '0;
      XI_PRdFinished <= 1'b0;
      XI_PRdSubA     <= '0;
      XI_PD          <= '0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      shreg          <= shreg_n;
      sda_oe         <= sda_oe_n;
      XI_PWr         <= pwr_n;
      XI_PRWA        <= prwa_n;
      XI_PRdFinished <= fin_n;
      XI_PRdSubA     <= sub_n;
      XI_PD          <= pd_n;
    end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    sda_oe_n  = sda_oe;
    pwr_n     = 1'b0;
    fin_n     = 1'b0;
    prwa_n    = XI_PRWA;
    sub_n     = XI_PRdSubA;
    pd_n      = XI_PD;
    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sub_n     = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ADDR:
          if (scl_rise) begin
            shreg_n   = nb;
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n  = addr_hit ? ADDR_ACK : IGNORE;
            sda_oe_n = addr_hit;
          end
        // shreg[0] still holds R/W; XO is loaded unconditionally since a write shifts it out anyway
        ADDR_ACK:
          if (scl_fall) begin
            state_n   = shreg[0] ? RD_BYTE : WR_BYTE;
            bit_cnt_n = '0;
            shreg_n   = XO;
            sda_oe_n  = shreg[0] & ~XO[7];
          end
        WR_BYTE:
          if (scl_rise) begin
            shreg_n   = nb;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              prwa_n = is_addr ? PW'(nb[TYPE_BITS+XA_BITS-1:TYPE_BITS]) : XI_PRWA;
              pd_n   = is_data ? nb[7:TYPE_BITS] : XI_PD;
              pwr_n  = is_data;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n  = WR_ACK;
            sda_oe_n = 1'b1;
          end
        WR_ACK:
          if (scl_fall) begin
            state_n   = WR_BYTE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
          end
        RD_BYTE:
          if (scl_fall) begin
            bit_cnt_n = bit_cnt + 4'd1;
            shreg_n   = {shreg[6:0], 1'b0};
            state_n   = bit_cnt == 4'd7 ? RD_ACK : RD_BYTE;
            sda_oe_n  = bit_cnt != 4'd7 && !shreg[6];
          end
        // A NACK leaves at the rising edge, so any later fall here follows an ACK
        RD_ACK:
          if (scl_rise) begin
            fin_n   = 1'b1;
            sub_n   = sda ? XI_PRdSubA : XI_PRdSubA + (XSUBA_MAX+1)'(1);
            state_n = sda ? IGNORE : RD_ACK;
          end else if (scl_fall) begin
            state_n   = RD_BYTE;
            bit_cnt_n = '0;
            shreg_n   = XO;
            sda_oe_n  = ~XO[7];
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pif_i2c_front.sv
// tb_pif_i2c_front: I2C master bench with a transaction-level model of the XI register side
module tb_pif_i2c_front;
  localparam int H = 8;
  logic xclk = 1'b0, sys_rst = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, XI_PWr, XI_PRdFinished, busy, sda_line;
  logic [7:0] XI_PRWA, XI_PRdSubA, XO;
  logic [5:0] XI_PD;
  logic [7:0] xo_mem [256];
  int n_vec = 0, n_err = 0, pwr_cnt = 0, fin_cnt = 0, oe_cnt = 0;
  logic [7:0] exp_prwa = 8'd0;
  logic [5:0] exp_pd = 6'd0;
  int exp_pwr = 0, exp_fin = 0;

  assign sda_line = sda_m & ~sda_oe;
  assign XO = xo_mem[XI_PRdSubA];
  always #5 xclk = ~xclk;

  pif_i2c_front dut (
    .xclk           (xclk),
    .sys_rst        (sys_rst),
    .scl_i          (scl_m),
    .sda_i          (sda_line),
    .sda_oe         (sda_oe),
    .XI_PWr         (XI_PWr),
    .XI_PRWA        (XI_PRWA),
    .XI_PRdFinished (XI_PRdFinished),
    .XI_PRdSubA     (XI_PRdSubA),
    .XI_PD          (XI_PD),
    .XO             (XO),
    .busy           (busy)
  );

  always @(negedge xclk) begin
    if (XI_PWr) pwr_cnt++;
    if (XI_PRdFinished) fin_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge xclk);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    tick(2);
    sda_m = b;
    tick(H-2);
    scl_m = 1'b1;
    tick(H/2);
    r = sda_line;
    tick(H/2);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    tick(2);
    sda_m = 1'b1;
    tick(H);
    scl_m = 1'b1;
    tick(H);
    sda_m = 1'b0;
    tick(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(2);
    sda_m = 1'b0;
    tick(H);
    scl_m = 1'b1;
    tick(H);
    sda_m = 1'b1;
    tick(H);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(nack, r);
  endtask

  // Register-side effect of one written byte: low two bits select address, data or nothing
  function automatic void model_wr(input logic [7:0] b);
    if (b[1:0] == 2'd0) exp_prwa = {5'd0, b[4:2]};
    if (b[1:0] == 2'd1) begin
      exp_pd = b[7:2];
      exp_pwr++;
    end
  endfunction

  initial begin
    logic a;
    logic [7:0] d, b;
    logic [6:0] ba;
    int kind, n, oe0;
    for (int i = 0; i < 256; i++) xo_mem[i] = 8'h50 + 8'(i);
    tick(4);
    chk("reset_outs", 32'({sda_oe, XI_PWr, XI_PRWA, XI_PRdFinished, XI_PRdSubA, XI_PD, busy}), 0);
    sys_rst = 1'b1;
    tick(4);

    i2c_start();
    wr_byte(8'h82, a); chk("wr_addr_ack", 32'(a), 0);
    chk("wr_busy", 32'(busy), 1);
    wr_byte(8'h04, a); chk("wr_b1_ack", 32'(a), 0); model_wr(8'h04);
    chk("wr_prwa", 32'(XI_PRWA), 1);
    wr_byte(8'hA9, a); chk("wr_b2_ack", 32'(a), 0); model_wr(8'hA9);
    i2c_stop();
    chk("wr_pwr_cnt", pwr_cnt, 1);
    chk("wr_pd", 32'(XI_PD), 32'h2A);
    chk("wr_idle", 32'(busy), 0);

    oe0 = oe_cnt;
    i2c_start();
    wr_byte(8'h84, a); chk("ign_addr_nack", 32'(a), 1);
    chk("ign_busy", 32'(busy), 0);
    wr_byte(8'h55, a); chk("ign_data_nack", 32'(a), 1);
    i2c_stop();
    chk("ign_pwr_cnt", pwr_cnt, exp_pwr);
    chk("ign_oe", oe_cnt - oe0, 0);

    i2c_start();
    wr_byte(8'h83, a); chk("rd_addr_ack", 32'(a), 0);
    for (int k = 0; k < 3; k++) begin
      rd_byte(k == 2, d);
      chk("rd_data", 32'(d), 32'(xo_mem[k]));
    end
    exp_fin += 3;
    chk("rd_nack_idle", 32'(busy), 0);
    i2c_stop();
    chk("rd_fin_cnt", fin_cnt, exp_fin);
    chk("rd_suba", 32'(XI_PRdSubA), 2);

    i2c_start();
    wr_byte(8'h82, a); chk("rs_addr_ack", 32'(a), 0);
    wr_byte(8'h08, a); chk("rs_b_ack", 32'(a), 0); model_wr(8'h08);
    i2c_start();
    chk("rs_suba", 32'(XI_PRdSubA), 0);
    wr_byte(8'h83, a); chk("rs_raddr_ack", 32'(a), 0);
    rd_byte(1'b1, d); chk("rs_data", 32'(d), 32'(xo_mem[0]));
    exp_fin++;
    chk("rs_prwa", 32'(XI_PRWA), 32'(exp_prwa));
    i2c_stop();

    for (int i = 0; i < 256; i++) xo_mem[i] = 8'($urandom);
    i2c_start();
    wr_byte(8'h83, a); chk("wrap_addr_ack", 32'(a), 0);
    for (int k = 0; k < 256; k++) begin
      rd_byte(1'b0, d);
      chk("wrap_data", 32'(d), 32'(xo_mem[k]));
    end
    chk("wrap_suba", 32'(XI_PRdSubA), 0);
    rd_byte(1'b1, d); chk("wrap_last", 32'(d), 32'(xo_mem[0]));
    exp_fin += 257;
    i2c_stop();
    chk("wrap_fin_cnt", fin_cnt, exp_fin);

    i2c_start();
    wr_byte(8'h83, a); chk("rst_addr_ack", 32'(a), 0);
    for (int k = 0; k < 4; k++) clk_bit(1'b1, a);
    tick(3);
    sys_rst = 1'b0;
    tick(2);
    chk("rst_mid_outs", 32'({sda_oe, XI_PWr, XI_PRWA, XI_PRdFinished, XI_PRdSubA, XI_PD, busy}), 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(H);
    sys_rst = 1'b1;
    tick(H);
    exp_prwa = 8'd0;
    exp_pd = 6'd0;
    i2c_start();
    wr_byte(8'h83, a); chk("rst_readdr_ack", 32'(a), 0);
    rd_byte(1'b1, d); chk("rst_data", 32'(d), 32'(xo_mem[0]));
    exp_fin++;
    i2c_stop();

    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      i2c_start();
      if (kind == 0) begin
        wr_byte(8'h82, a); chk("rnd_wr_addr_ack", 32'(a), 0);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          wr_byte(b, a); chk("rnd_wr_ack", 32'(a), 0);
          model_wr(b);
        end
      end else if (kind == 1) begin
        wr_byte(8'h83, a); chk("rnd_rd_addr_ack", 32'(a), 0);
        for (int k = 0; k < n; k++) begin
          rd_byte(k == n - 1, d);
          chk("rnd_rd_data", 32'(d), 32'(xo_mem[k]));
        end
        exp_fin += n;
      end else begin
        do ba = 7'($urandom); while (ba == 7'h41);
        wr_byte({ba, 1'($urandom)}, a); chk("rnd_bad_nack", 32'(a), 1);
        wr_byte(8'($urandom), a); chk("rnd_bad_data_nack", 32'(a), 1);
      end
      i2c_stop();
      chk("rnd_prwa", 32'(XI_PRWA), 32'(exp_prwa));
      chk("rnd_pd", 32'(XI_PD), 32'(exp_pd));
      chk("rnd_pwr_cnt", pwr_cnt, exp_pwr);
      chk("rnd_fin_cnt", fin_cnt, exp_fin);
      chk("rnd_suba", 32'(XI_PRdSubA), kind == 1 ? 32'(n - 1) : 0);
      chk("rnd_idle", 32'(busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
